// File: rtl/cmp_share_pkg.sv
// Shared types and constants for the compare-sharing arbiter.
package cmp_share_pkg;

    localparam int W_DEF    = 4;
    localparam int NREQ_DEF = 4;
    localparam int ID_W     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_share_arbiter_if.sv
// Request/response bundle between requesters, consumer and the arbiter.
interface cmp_share_arbiter_if #(
    parameter int W    = 4,
    parameter int NREQ = 4
);
    import cmp_share_pkg::*;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [ID_W-1:0]   resp_id;
    logic              resp_lt;
    logic              resp_eq;
    logic              resp_gt;
    logic              busy;

    modport master (
        output req_valid, req_x, req_y, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_lt, resp_eq, resp_gt, busy
    );

    modport slave (
        input  req_valid, req_x, req_y, resp_ready,
        output req_ready, resp_valid, resp_id, resp_lt, resp_eq, resp_gt, busy
    );

endinterface

// File: rtl/mag_cmp.sv
// Unsigned W-bit magnitude comparator, purely combinational.
module mag_cmp #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         lt,
    output logic         eq,
    output logic         gt
);

    assign lt = (x < y);
    assign eq = (x == y);
    assign gt = (x > y);

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator among NREQ requesters.
// Optional macro CMP_SHARE_STATS_EN adds an 8-bit saturating handshake counter.
module cmp_share_arbiter
    import cmp_share_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic               clk,
    input  logic               rst,
    cmp_share_arbiter_if.slave bus
`ifdef CMP_SHARE_STATS_EN
    ,
    output logic [7:0]         cmp_count
`endif
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_sel;
    logic [ID_W-1:0]   r_id;
    logic [W-1:0]      r_x;
    logic [W-1:0]      r_y;
    logic              r_lt;
    logic              r_eq;
    logic              r_gt;

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_grant;
    logic [ID_W-1:0]   w_gidx;
    logic              w_any;
    logic              w_accept;
    logic [W-1:0]      w_x_sel;
    logic [W-1:0]      w_y_sel;
    logic              w_lt;
    logic              w_eq;
    logic              w_gt;
    logic              w_resp_valid;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return ID_W'(s);
    endfunction

    // Rotate requests so bit 0 is the pointer position; first set bit wins.
    always_comb begin
        w_dbl  = {bus.req_valid, bus.req_valid} >> r_ptr;
        w_gidx = '0;
        w_any  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_any && w_dbl[k]) begin
                w_gidx = wrap_add(r_ptr, k);
                w_any  = 1'b1;
            end
        end
        w_grant = w_any ? (NREQ'(1) << w_gidx) : '0;
    end

    assign w_accept = (r_state == IDLE) && w_any;
    assign w_x_sel  = W'(bus.req_x >> (int'(w_gidx) * W));
    assign w_y_sel  = W'(bus.req_y >> (int'(w_gidx) * W));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_state_nxt = CMP;
            CMP:     w_state_nxt = RESP;
            RESP:    if (bus.resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    mag_cmp #(
        .W (W)
    ) u_mag_cmp (
        .x  (r_x),
        .y  (r_y),
        .lt (w_lt),
        .eq (w_eq),
        .gt (w_gt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_id    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ptr <= wrap_add(w_gidx, 1);
                r_sel <= w_gidx;
                r_x   <= w_x_sel;
                r_y   <= w_y_sel;
            end
            if (r_state == CMP) begin
                r_lt <= w_lt;
                r_eq <= w_eq;
                r_gt <= w_gt;
                r_id <= r_sel;
            end
        end
    end

    assign w_resp_valid   = (r_state == RESP);
    // Gate with rst so the strobe drops the instant reset asserts.
    assign bus.req_ready  = ((r_state == IDLE) && !rst) ? w_grant : '0;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_id    = r_id;
    assign bus.resp_lt    = r_lt;
    assign bus.resp_eq    = r_eq;
    assign bus.resp_gt    = r_gt;
    assign bus.busy       = (r_state != IDLE);

`ifdef CMP_SHARE_STATS_EN
    logic [7:0] r_cmp_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp_count <= '0;
        end else if (w_resp_valid && bus.resp_ready && (r_cmp_count != 8'hFF)) begin
            r_cmp_count <= r_cmp_count + 8'd1;
        end
    end

    assign cmp_count = r_cmp_count;
`endif

endmodule

// File: doc/cmp_share_arbiter.md
CMP_SHARE_ARBITER -- requirements
Module: cmp_share_arbiter

Interface
REQ-001 SHALL have parameter W, default 4, operand width in bits.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters; legal values are 2..8.
REQ-003 SHALL have port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester compare request.
REQ-006 SHALL have port req_x  input  NREQ*W  X operands; requester i occupies bits [i*W +: W].
REQ-007 SHALL have port req_y  input  NREQ*W  Y operands, packed the same way as req_x.
REQ-008 SHALL have port req_ready  output  NREQ  one-hot accept strobe.
REQ-009 SHALL have port resp_valid  output  1  result available.
REQ-010 SHALL have port resp_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port resp_id  output  3  index of the served requester.
REQ-012 SHALL have port resp_lt, resp_eq, resp_gt  output  1 each  unsigned X<Y, X==Y, X>Y.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CMP and RESP.
REQ-015 IDLE: if any req_valid is high, SHALL grant exactly one requester, capture its X and Y into registers, and go to CMP; otherwise SHALL stay in IDLE.
REQ-016 req_ready SHALL be combinational, SHALL be non-zero only in IDLE, and SHALL equal the one-hot grant; a transfer is req_valid[i] & req_ready[i].
REQ-017 Arbitration SHALL be round-robin: search starts at pointer ptr, and ptr becomes (grant+1) mod NREQ on each accept.
REQ-018 CMP: the single shared comparator SHALL evaluate the captured operands and register lt/eq/gt/id; the FSM SHALL then go to RESP.
REQ-019 RESP: resp_valid SHALL be high; outputs SHALL be held stable until resp_valid & resp_ready, after which the FSM SHALL return to IDLE.
REQ-020 Latency: resp_valid SHALL rise exactly 2 cycles after the accept edge; minimum issue interval is 3 cycles.
REQ-021 Exactly one of resp_lt/eq/gt SHALL be high whenever resp_valid is high.
REQ-022 Comparison SHALL be unsigned on W bits.
REQ-023 Requests arriving outside IDLE SHALL be ignored (not queued); req_valid may drop before acceptance without side effects.
REQ-024 Simultaneous requests SHALL be resolved by REQ-017 only; no requester SHALL wait more than NREQ-1 grants.
REQ-025 ptr SHALL wrap from NREQ-1 to 0.

Reset
REQ-026 rst high SHALL immediately force: state=IDLE, ptr=0, req_ready=0, resp_valid=0, resp_id=0, resp_lt/eq/gt=0, busy=0, captured operands=0.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight request with no response.

Configuration
REQ-028 Macro CMP_SHARE_STATS_EN: when defined, port cmp_count (output, 8 bits) SHALL exist and SHALL count completed response handshakes, saturating at 255 and reset to 0.
REQ-029 Without CMP_SHARE_STATS_EN, the port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Shared package cmp_share_pkg SHALL hold the FSM state typedef (IDLE/CMP/RESP) and the constants W_DEF=4, NREQ_DEF=4 and ID_W=3.
REQ-031 The comparator SHALL be a separate combinational sub-module mag_cmp, W-parameterised, with outputs lt/eq/gt, instantiated once.

Verification
REQ-032 Requester 0 sends X=6, Y=9, resp_ready=1 -> 2 cycles after accept: resp_valid=1, id=0, lt=1.
REQ-033 Requester 2 sends X=12, Y=7, then requester 1 sends X=8, Y=8 -> responses are id=2 gt=1, then id=1 eq=1.
REQ-034 All 4 valid continuously, all with X=Y=15, from reset -> grant order is 0,1,2,3,0 and each response has eq=1.
REQ-035 resp_ready held low for 5 cycles -> resp_valid, id and flags stay stable, req_ready stays 0, then exactly one handshake occurs.
REQ-036 rst pulsed during CMP -> no response; ptr=0; the next grant goes to the lowest valid index.
REQ-037 With CMP_SHARE_STATS_EN, 300 back-to-back compares -> cmp_count=255.
